scard_t0_seq: RTL and testbench

SCARD_T0_SEQ -- requirements
Module: scard_t0_seq

---
 rtl/scard_t0_seq_if.sv | 21 ++
 rtl/scard_t0_seq.sv | 204 ++++++++++++++++++++
 tb/tb_scard_t0_seq.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scard_t0_seq_if.sv
// Byte-wide strobe interface to the smartcard serial FIFOs (rx side feeds card
// bytes in, tx side carries header and payload bytes out to the card).
interface scard_t0_seq_if;
    logic       scardfifo_rxe;
    logic       scardfifo_txf;
    logic       scardfifo_txe;
    logic [7:0] scardfifo_din;
    logic       scardfifo_rd;
    logic       scardfifo_wr;
    logic [7:0] scardfifo_dout;

    modport master (
        input  scardfifo_rxe, scardfifo_txf, scardfifo_txe, scardfifo_din,
        output scardfifo_rd, scardfifo_wr, scardfifo_dout
    );

    modport slave (
        output scardfifo_rxe, scardfifo_txf, scardfifo_txe, scardfifo_din,
        input  scardfifo_rd, scardfifo_wr, scardfifo_dout
    );
endinterface

// File: rtl/scard_t0_seq.sv
// ISO7816 T=0 command sequencer: sends the 5-byte header, follows the card's
// procedure bytes to move payload in either direction, and collects SW1/SW2.
module scard_t0_seq #(
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 cmd_start,
    input  logic [39:0]          cmd_hdr,
    input  logic                 cmd_dir,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status,
    output logic [15:0]          sw,
    input  logic [7:0]           txd_data,
    input  logic                 txd_valid,
    output logic                 txd_ready,
    output logic [7:0]           rxd_data,
    output logic                 rxd_valid,
    scard_t0_seq_if.master       fifo
);

    typedef enum logic [3:0] {
        S_IDLE, S_FLUSH, S_HDR, S_PWAIT, S_PRD,
        S_SEND_ALL, S_SEND_ONE, S_RECV, S_SW2, S_FIN
    } state_t;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_TMO  = 2'b01;
    localparam logic [1:0] ST_PERR = 2'b10;

    state_t               state_q, state_d;
    logic [8:0]           n_q, n_d;
    logic [2:0]           hcnt_q, hcnt_d;
    logic                 one_q, one_d;
    logic                 rd_pend;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_nxt;
    logic [1:0]           status_q, status_d;
    logic [15:0]          sw_q, sw_d;
    logic [39:0]          hdr_q;
    logic [7:0]           ins_q;
    logic                 dir_q;
    logic                 ld_cmd, hdr_sh, tmo_clr, tmo_inc;
    logic                 idle_wait, tmo_hit;
    logic [7:0]           pbyte;

    // The wait counter only advances while both directions of the line are quiet.
    assign idle_wait = fifo.scardfifo_txe & fifo.scardfifo_rxe;
    assign tmo_nxt   = tmo_q + TIMEOUT_W'(1);
    assign tmo_hit   = idle_wait && (tmo_nxt == timeout_i);
    assign pbyte     = fifo.scardfifo_din;

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FIN);
    assign status   = status_q;
    assign sw       = sw_q;
    assign rxd_data = fifo.scardfifo_din;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        hcnt_d   = hcnt_q;
        one_d    = one_q;
        status_d = status_q;
        sw_d     = sw_q;
        ld_cmd   = 1'b0;
        hdr_sh   = 1'b0;
        tmo_clr  = 1'b0;
        tmo_inc  = 1'b0;
        fifo.scardfifo_rd   = 1'b0;
        fifo.scardfifo_wr   = 1'b0;
        fifo.scardfifo_dout = hdr_q[39:32];
        txd_ready = 1'b0;
        rxd_valid = 1'b0;
        unique case (state_q)
            S_IDLE: if (cmd_start) begin
                ld_cmd   = 1'b1;
                n_d      = (!cmd_dir && cmd_hdr[7:0] == 8'd0) ? 9'd256 : {1'b0, cmd_hdr[7:0]};
                hcnt_d   = 3'd0;
                one_d    = 1'b0;
                status_d = ST_OK;
                sw_d     = 16'h0000;
                state_d  = S_FLUSH;
            end
            S_FLUSH: if (!rd_pend) begin
                if (!fifo.scardfifo_rxe) fifo.scardfifo_rd = 1'b1;
                else                     state_d = S_HDR;
            end
            S_HDR: if (!fifo.scardfifo_txf) begin
                fifo.scardfifo_wr = 1'b1;
                hdr_sh = 1'b1;
                hcnt_d = hcnt_q + 3'd1;
                if (hcnt_q == 3'd4) state_d = S_PWAIT;
            end
            S_PWAIT: begin
                if (!fifo.scardfifo_rxe) begin
                    fifo.scardfifo_rd = 1'b1;
                    state_d = S_PRD;
                end else begin
                    tmo_inc = idle_wait;
                    if (tmo_hit) begin status_d = ST_TMO; state_d = S_FIN; end
                end
            end
            // Procedure byte is on din this cycle; NULL loops back with a fresh timeout.
            S_PRD: begin
                if (pbyte == 8'h60) begin
                    state_d = S_PWAIT;
                end else if (pbyte == ins_q || pbyte == ~ins_q) begin
                    if (n_q == 9'd0) begin
                        status_d = ST_PERR;
                        state_d  = S_FIN;
                    end else begin
                        one_d = (pbyte != ins_q);
                        if (!dir_q)                state_d = S_RECV;
                        else if (pbyte == ins_q)   state_d = S_SEND_ALL;
                        else                       state_d = S_SEND_ONE;
                    end
                end else if (pbyte[7:4] == 4'h6 || pbyte[7:4] == 4'h9) begin
                    sw_d    = {pbyte, sw_q[7:0]};
                    state_d = S_SW2;
                end else begin
                    status_d = ST_PERR;
                    state_d  = S_FIN;
                end
            end
            S_SEND_ALL, S_SEND_ONE: begin
                if (n_q == 9'd0) begin
                    state_d = S_PWAIT;
                end else begin
                    txd_ready = !fifo.scardfifo_txf;
                    if (txd_valid && !fifo.scardfifo_txf) begin
                        fifo.scardfifo_wr   = 1'b1;
                        fifo.scardfifo_dout = txd_data;
                        n_d = n_q - 9'd1;
                        if (state_q == S_SEND_ONE) state_d = S_PWAIT;
                    end
                end
            end
            S_RECV: begin
                if (rd_pend) begin
                    rxd_valid = 1'b1;
                    n_d       = n_q - 9'd1;
                    tmo_clr   = 1'b1;
                    if (one_q || n_q == 9'd1) state_d = S_PWAIT;
                end else if (!fifo.scardfifo_rxe) begin
                    fifo.scardfifo_rd = 1'b1;
                end else begin
                    tmo_inc = idle_wait;
                    if (tmo_hit) begin status_d = ST_TMO; state_d = S_FIN; end
                end
            end
            S_SW2: begin
                if (rd_pend) begin
                    sw_d     = {sw_q[15:8], pbyte};
                    status_d = ST_OK;
                    state_d  = S_FIN;
                end else if (!fifo.scardfifo_rxe) begin
                    fifo.scardfifo_rd = 1'b1;
                end else begin
                    tmo_inc = idle_wait;
                    if (tmo_hit) begin status_d = ST_TMO; state_d = S_FIN; end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            n_q      <= 9'd0;
            hcnt_q   <= 3'd0;
            one_q    <= 1'b0;
            rd_pend  <= 1'b0;
            tmo_q    <= '0;
            status_q <= ST_OK;
            sw_q     <= 16'h0000;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            hcnt_q   <= hcnt_d;
            one_q    <= one_d;
            rd_pend  <= fifo.scardfifo_rd;
            status_q <= status_d;
            sw_q     <= sw_d;
            if (tmo_clr || state_d != state_q) tmo_q <= '0;
            else if (tmo_inc)                  tmo_q <= tmo_nxt;
        end
    end

    // Header shifts out MSB-first so CLA leaves first and P3 last.
    always_ff @(posedge clk_i) begin
        if (ld_cmd) begin
            hdr_q <= cmd_hdr;
            ins_q <= cmd_hdr[31:24];
            dir_q <= cmd_dir;
        end else if (hdr_sh) begin
            hdr_q <= {hdr_q[31:0], 8'h00};
        end
    end

endmodule

// File: tb/tb_scard_t0_seq.sv
// Directed bench for scard_t0_seq: behavioural rx/tx FIFO and payload source
// around the sequencer, with one task per scenario.
module tb_scard_t0_seq;
    localparam int TW = 24;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          cmd_start = 1'b0;
    logic [39:0]   cmd_hdr = '0;
    logic          cmd_dir = 1'b0;
    logic [TW-1:0] timeout_i = 24'd1000;
    logic          busy, done;
    logic [1:0]    status;
    logic [15:0]   sw;
    logic [7:0]    txd_data;
    logic          txd_valid, txd_ready;
    logic [7:0]    rxd_data;
    logic          rxd_valid;

    scard_t0_seq_if sif();

    scard_t0_seq #(.TIMEOUT_W(TW)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cmd_start(cmd_start), .cmd_hdr(cmd_hdr), .cmd_dir(cmd_dir),
        .timeout_i(timeout_i),
        .busy(busy), .done(done), .status(status), .sw(sw),
        .txd_data(txd_data), .txd_valid(txd_valid), .txd_ready(txd_ready),
        .rxd_data(rxd_data), .rxd_valid(rxd_valid),
        .fifo(sif)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] rx_mem [0:255];
    int         rx_wr = 0, rx_rd = 0;
    logic [7:0] din_r = 8'h00;
    logic       txf = 1'b0, txf_toggle = 1'b0, txe = 1'b1;
    logic [7:0] pl_mem [0:63];
    int         pl_wr = 0, pl_rd = 0;
    logic [7:0] txlog[$];
    int         txrd[$];
    logic [7:0] rxlog[$];
    int         rdcnt = 0, viol_wr = 0, viol_rd = 0, cyc = 0, last_rd_cyc = 0;
    int         n_chk = 0, n_fail = 0;
    int         tx_base = 0, rx_base = 0, rd_base = 0;

    assign sif.scardfifo_rxe = (rx_rd == rx_wr);
    assign sif.scardfifo_txf = txf;
    assign sif.scardfifo_txe = txe;
    assign sif.scardfifo_din = din_r;
    assign txd_valid = (pl_rd != pl_wr);
    assign txd_data  = pl_mem[pl_rd % 64];

    // FIFO model: 1-cycle read latency on rx, logging of every tx write.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (sif.scardfifo_rd) begin
            if (sif.scardfifo_rxe) viol_rd <= viol_rd + 1;
            else begin
                din_r <= rx_mem[rx_rd % 256];
                rx_rd <= rx_rd + 1;
            end
            rdcnt <= rdcnt + 1;
            last_rd_cyc <= cyc;
        end
        if (sif.scardfifo_wr) begin
            if (txf) viol_wr <= viol_wr + 1;
            txlog.push_back(sif.scardfifo_dout);
            txrd.push_back(rdcnt);
        end
        if (rxd_valid) rxlog.push_back(rxd_data);
        if (txd_valid && txd_ready) pl_rd <= pl_rd + 1;
    end

    always @(negedge clk_i) txf <= txf_toggle ? ~txf : 1'b0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic push_rx(input logic [7:0] b);
        rx_mem[rx_wr % 256] = b;
        rx_wr = rx_wr + 1;
    endtask

    task automatic push_pl(input logic [7:0] b);
        pl_mem[pl_wr % 64] = b;
        pl_wr = pl_wr + 1;
    endtask

    task automatic start_cmd(input logic [39:0] h, input logic d);
        @(negedge clk_i);
        tx_base = txlog.size();
        rx_base = rxlog.size();
        rd_base = rdcnt;
        cmd_hdr = h;
        cmd_dir = d;
        cmd_start = 1'b1;
        @(negedge clk_i);
        cmd_start = 1'b0;
    endtask

    task automatic wait_hdr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (txlog.size() >= tx_base + 5) begin ok = 1'b1; break; end
            @(negedge clk_i);
        end
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk_i);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_chk++; if (status !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b expected 00", status); end
        n_chk++; if (sw !== 16'h0000) begin n_fail++; $display("FAIL reset_sw: got %h expected 0000", sw); end
        n_chk++;
        if ({sif.scardfifo_rd, sif.scardfifo_wr, rxd_valid, txd_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 0000",
                               {sif.scardfifo_rd, sif.scardfifo_wr, rxd_valid, txd_ready});
        end
        reset_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_incoming();
        bit ok;
        logic [39:0] got;
        logic [15:0] got16;
        start_cmd(40'h00B0000002, 1'b0);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL in_busy: got %b expected 1", busy); end
        wait_hdr(ok);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL in_hdr_wait: got %b expected 1", ok); end
        push_rx(8'hB0); push_rx(8'h11); push_rx(8'h22); push_rx(8'h90); push_rx(8'h00);
        wait_done(300, ok);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL in_done: got %b expected 1", ok); end
        got = '0;
        for (int i = 0; i < 5; i++) if (tx_base + i < txlog.size()) got = {got[31:0], txlog[tx_base + i]};
        n_chk++; if (got !== 40'h00B0000002) begin n_fail++; $display("FAIL in_header: got %h expected 00b0000002", got); end
        got16 = '0;
        for (int i = 0; i < 2; i++) if (rx_base + i < rxlog.size()) got16 = {got16[7:0], rxlog[rx_base + i]};
        n_chk++; if (got16 !== 16'h1122) begin n_fail++; $display("FAIL in_rxd: got %h expected 1122", got16); end
        n_chk++; if (rxlog.size() - rx_base !== 2) begin n_fail++; $display("FAIL in_rxd_count: got %0d expected 2", rxlog.size() - rx_base); end
        n_chk++; if (status !== 2'b00) begin n_fail++; $display("FAIL in_status: got %b expected 00", status); end
        n_chk++; if (sw !== 16'h9000) begin n_fail++; $display("FAIL in_sw: got %h expected 9000", sw); end
        @(negedge clk_i);
        n_chk++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL in_after_done: got %b expected 00", {busy, done}); end
        n_chk++; if (status !== 2'b00) begin n_fail++; $display("FAIL in_status_held: got %b expected 00", status); end
    endtask

    task automatic test_outgoing_nack();
        bit ok;
        logic [15:0] got16;
        int r5, r6;
        push_pl(8'hAA); push_pl(8'hBB);
        start_cmd(40'h80D6000002, 1'b1);
        wait_hdr(ok);
        push_rx(8'h29); push_rx(8'h29); push_rx(8'h90); push_rx(8'h00);
        wait_done(300, ok);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL out_done: got %b expected 1", ok); end
        got16 = '0;
        for (int i = 5; i < 7; i++) if (tx_base + i < txlog.size()) got16 = {got16[7:0], txlog[tx_base + i]};
        n_chk++; if (got16 !== 16'hAABB) begin n_fail++; $display("FAIL out_payload: got %h expected aabb", got16); end
        n_chk++; if (txlog.size() - tx_base !== 7) begin n_fail++; $display("FAIL out_wr_count: got %0d expected 7", txlog.size() - tx_base); end
        r5 = -1; r6 = -1;
        if (txrd.size() > tx_base + 5) r5 = txrd[tx_base + 5] - rd_base;
        if (txrd.size() > tx_base + 6) r6 = txrd[tx_base + 6] - rd_base;
        n_chk++; if (r5 !== 1) begin n_fail++; $display("FAIL out_first_after_nack: reads before byte got %0d expected 1", r5); end
        n_chk++; if (r6 !== 2) begin n_fail++; $display("FAIL out_second_after_nack: reads before byte got %0d expected 2", r6); end
        n_chk++; if (status !== 2'b00) begin n_fail++; $display("FAIL out_status: got %b expected 00", status); end
        n_chk++; if (sw !== 16'h9000) begin n_fail++; $display("FAIL out_sw: got %h expected 9000", sw); end
    endtask

    task automatic test_null_timeout();
        bit ok;
        int dt;
        timeout_i = 24'd100;
        start_cmd(40'h00B0000001, 1'b0);
        wait_hdr(ok);
        repeat (50) @(negedge clk_i);
        push_rx(8'h60);
        wait_done(400, ok);
        dt = cyc - last_rd_cyc;
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tmo_done: got %b expected 1", ok); end
        n_chk++; if (status !== 2'b01) begin n_fail++; $display("FAIL tmo_status: got %b expected 01", status); end
        // rd cycle, capture cycle, 100 counted idle cycles, then FIN
        n_chk++; if (dt !== 102) begin n_fail++; $display("FAIL tmo_latency: got %0d expected 102 cycles from rd to done", dt); end
        n_chk++; if (rdcnt - rd_base !== 1) begin n_fail++; $display("FAIL tmo_reads: got %0d expected 1", rdcnt - rd_base); end
        timeout_i = 24'd1000;
        @(negedge clk_i);
    endtask

    task automatic test_proto_err();
        bit ok;
        int tx0, rd0;
        start_cmd(40'h00A4000002, 1'b1);
        wait_hdr(ok);
        push_rx(8'h42);
        wait_done(300, ok);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL perr_done: got %b expected 1", ok); end
        n_chk++; if (status !== 2'b10) begin n_fail++; $display("FAIL perr_status: got %b expected 10", status); end
        tx0 = txlog.size(); rd0 = rdcnt;
        repeat (20) @(negedge clk_i);
        n_chk++; if (txlog.size() - tx_base !== 5) begin n_fail++; $display("FAIL perr_wr_count: got %0d expected 5", txlog.size() - tx_base); end
        n_chk++; if ((txlog.size() - tx0) + (rdcnt - rd0) !== 0) begin
            n_fail++; $display("FAIL perr_quiet: got %0d strobes expected 0", (txlog.size() - tx0) + (rdcnt - rd0));
        end
    endtask

    task automatic test_ack_n0();
        bit ok;
        start_cmd(40'h00D6000000, 1'b1);
        wait_hdr(ok);
        push_rx(8'hD6);
        wait_done(300, ok);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ackn0_done: got %b expected 1", ok); end
        n_chk++; if (status !== 2'b10) begin n_fail++; $display("FAIL ackn0_status: got %b expected 10", status); end
        n_chk++; if (txlog.size() - tx_base !== 5) begin n_fail++; $display("FAIL ackn0_wr_count: got %0d expected 5", txlog.size() - tx_base); end
    endtask

    task automatic test_flush_backpressure();
        bit ok;
        logic [39:0] got;
        int r0;
        push_rx(8'h55); push_rx(8'h66); push_rx(8'h77);
        txf_toggle = 1'b1;
        start_cmd(40'h00B0000001, 1'b0);
        wait_hdr(ok);
        txf_toggle = 1'b0;
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fl_hdr_wait: got %b expected 1", ok); end
        r0 = -1;
        if (txrd.size() > tx_base) r0 = txrd[tx_base] - rd_base;
        n_chk++; if (r0 !== 3) begin n_fail++; $display("FAIL fl_discards: got %0d expected 3", r0); end
        got = '0;
        for (int i = 0; i < 5; i++) if (tx_base + i < txlog.size()) got = {got[31:0], txlog[tx_base + i]};
        n_chk++; if (got !== 40'h00B0000001) begin n_fail++; $display("FAIL fl_header: got %h expected 00b0000001", got); end
        n_chk++; if (viol_wr !== 0) begin n_fail++; $display("FAIL fl_wr_while_full: got %0d expected 0", viol_wr); end
        push_rx(8'hB0); push_rx(8'h5A); push_rx(8'h90); push_rx(8'h00);
        wait_done(300, ok);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fl_done: got %b expected 1", ok); end
        n_chk++; if (rxlog.size() - rx_base !== 1) begin n_fail++; $display("FAIL fl_rxd_count: got %0d expected 1", rxlog.size() - rx_base); end
        n_chk++; if (rxlog.size() > rx_base && rxlog[rx_base] !== 8'h5A) begin n_fail++; $display("FAIL fl_rxd: got %h expected 5a", rxlog[rx_base]); end
        n_chk++; if ({status, sw} !== 18'h09000) begin n_fail++; $display("FAIL fl_status_sw: got %h expected 09000", {status, sw}); end
    endtask

    task automatic test_reset_mid_recv();
        bit ok;
        logic [15:0] got16;
        start_cmd(40'h00B0000004, 1'b0);
        wait_hdr(ok);
        push_rx(8'hB0); push_rx(8'h11);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (rxlog.size() >= rx_base + 1) begin ok = 1'b1; break; end
        end
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_first_byte: got %b expected 1", ok); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_before: got %b expected 1", busy); end
        reset_i = 1'b1;
        #1;
        n_chk++;
        if ({busy, done, status, sw, rxd_valid, txd_ready, sif.scardfifo_rd, sif.scardfifo_wr} !== 24'h0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %h expected 000000",
                               {busy, done, status, sw, rxd_valid, txd_ready, sif.scardfifo_rd, sif.scardfifo_wr});
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        repeat (3) @(negedge clk_i);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_no_resume: got %b expected 0", busy); end
        start_cmd(40'h00B0000002, 1'b0);
        wait_hdr(ok);
        push_rx(8'hB0); push_rx(8'h33); push_rx(8'h44); push_rx(8'h61); push_rx(8'h10);
        wait_done(300, ok);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_new_done: got %b expected 1", ok); end
        got16 = '0;
        for (int i = 0; i < 2; i++) if (rx_base + i < rxlog.size()) got16 = {got16[7:0], rxlog[rx_base + i]};
        n_chk++; if (got16 !== 16'h3344) begin n_fail++; $display("FAIL rst_new_rxd: got %h expected 3344", got16); end
        n_chk++; if ({status, sw} !== 18'h06110) begin n_fail++; $display("FAIL rst_new_status_sw: got %h expected 06110", {status, sw}); end
        n_chk++; if (viol_rd !== 0) begin n_fail++; $display("FAIL rd_while_empty: got %0d expected 0", viol_rd); end
        n_chk++; if (viol_wr !== 0) begin n_fail++; $display("FAIL wr_while_full: got %0d expected 0", viol_wr); end
    endtask

    initial begin
        test_reset();
        test_incoming();
        test_outgoing_nack();
        test_null_timeout();
        test_proto_err();
        test_ack_n0();
        test_flush_backpressure();
        test_reset_mid_recv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
